pc_predict_gen: RTL and testbench
=================================

Name: pc_predict_gen

Overview:
Parametrised fetch-address generator. It statically predicts control flow (JAL, backward conditional branches, returns through a return-address stack) and buffers pre-decoded instructions toward the register stage in a valid/ready FIFO. Sits between instruction fetch and register read. Generalises PC generation with configurable XLEN, RAS depth and buffer depth, explicit backpressure, and redirect on flush.

Parameters:
XLEN, 32, address/data width (≥32).
RAS_DEPTH, 4, return-address-stack entries (power of 2, ≥2).
FIFO_DEPTH, 2, output buffer entries (power of 2, ≥2).

Ports:
clk  in  1  clock.
rst_n  in  1  reset, synchronous, active-low.
start_address  in  XLEN  first fetch address, sampled in INIT.
fetch_req_o  out  1  fetch request valid for fetch_pc_o.
fetch_pc_o  out  XLEN  address of instruction expected on instr_i.
instr_i  in  32  instruction at fetch_pc_o.
instr_valid_i  in  1  instr_i valid.
instr_ready_o  out  1  block accepts instr_i this cycle.
out_valid_o  out  1  FIFO head valid.
out_ready_i  in  1  register stage consumes head.
out_instr_o  out  32  head instruction.
out_pc_o  out  XLEN  head PC.
out_pred_taken_o  out  1  head predicted taken.
out_pred_target_o  out  XLEN  head predicted target (pc+4 when not taken).
flush_i  in  1  redirect request.
flush_pc_i  in  XLEN  redirect address.

Behaviour:
- Reset is synchronous, active-low on clk. While rst_n=0: state RESET, pc=0, FIFO empty, RAS empty (count 0, top pointer 0), fetch_req_o=0, instr_ready_o=0, out_valid_o=0, all data outputs 0.
- FSM: RESET → INIT (first cycle with rst_n=1; pc <= start_address) → RUN (fetch_req_o=1, fetch_pc_o=pc). RUN persists until reset.
- instr_ready_o = (state==RUN) & !FIFO_full & !flush_i. Accept = instr_valid_i & instr_ready_o.
- On accept, pre-decode instr_i (opcode [6:0], rd [11:7], rs1 [19:15]) to produce next_pc:
  * JAL (1101111): taken, target = pc + sext(J-imm). If rd∈{x1,x5}, push pc+4.
  * JALR (1100111), rd=x0, rs1∈{x1,x5} (return): if RAS non-empty, pop; taken, target = popped value. If empty: not taken, target = pc+4.
  * JALR with rd∈{x1,x5}: push pc+4; not taken. If the same instruction is also a return (rs1∈{x1,x5}, rs1≠rd), pop first, then push; taken to the popped value.
  * Branch (1100011): taken iff imm[12]=1 (backward); target = pc + sext(B-imm). Else pc+4.
  * Other: not taken, target = pc+4.
  * Target arithmetic is modulo 2^XLEN; no alignment check.
- Accept updates: pc <= target; FIFO pushes {instr, pc, taken, target}. The entry is visible on out_* the next cycle (1-cycle latency).
- No accept: pc holds and fetch_pc_o stays stable.
- RAS is circular. A push when full overwrites the oldest entry; count saturates at RAS_DEPTH. A pop when empty makes no change.
- FIFO pop = out_valid_o & out_ready_i. A simultaneous push and pop when full is not possible, because ready is low when full. When not full, both take effect.
- flush_i=1 in RUN:
  * Next cycle, pc = flush_pc_i and the FIFO is emptied.
  * Any same-cycle accept or pop is discarded, and the RAS is unchanged by it.
  * RAS contents are kept (no repair).
- flush_i in RESET/INIT is ignored.
- rst_n low mid-operation returns to RESET on the next edge and discards everything.

Test Plan:
- Reset then start_address=0x1000, 3 NOPs (0x00000013) valid every cycle, out_ready_i=1: fetch_pc_o 0x1000, 0x1004, 0x1008. out_pc_o follows one cycle later, pred_taken=0.
- At 0x2000, JAL x1,+0x100 (0x100000EF): next fetch_pc_o=0x2100, out_pred_target_o=0x2100. Then RET (0x00008067) at 0x2100 → next fetch 0x2004, taken=1.
- BEQ x0,x0,-8 (0xFE000CE3) at 0x3008: fetch_pc_o → 0x3000, taken=1. BEQ +8 at 0x3000 → 0x3004, taken=0.
- out_ready_i=0, FIFO_DEPTH=2, instructions always valid: exactly 2 accepts, then instr_ready_o=0 and fetch_pc_o holds. Raise out_ready_i: one pop per cycle, and acceptance resumes the same cycle the FIFO stops being full.
- RAS_DEPTH=4, 5 nested JAL x1 calls at 0x100, 0x200, 0x300, 0x400, 0x500 (targets 0x200…0x600), then 5 RETs: returns predict 0x504, 0x404, 0x304, 0x204, then the 5th is not taken (0x104 entry overwritten, stack empty).
- flush_i=1 with flush_pc_i=0x8000, simultaneous instr_valid_i and FIFO holding 2 entries: next cycle out_valid_o=0 and fetch_pc_o=0x8000, the dropped instruction is never output, and RAS count is unchanged.

Source files
------------

// File: rtl/pc_predict_gen.sv
// Fetch-address generator: statically predicts JAL, backward branches and returns (via a
// circular return-address stack) and queues pre-decoded instructions toward register read.
module pc_predict_gen #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned RAS_DEPTH  = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] start_address,
    output logic            fetch_req_o,
    output logic [XLEN-1:0] fetch_pc_o,
    input  logic [31:0]     instr_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     out_instr_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic            out_pred_taken_o,
    output logic [XLEN-1:0] out_pred_target_o,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i
);
    localparam int unsigned RAW = $clog2(RAS_DEPTH);
    localparam int unsigned FAW = $clog2(FIFO_DEPTH);
    localparam logic [RAW:0] RAS_FULL  = (RAW + 1)'(RAS_DEPTH);
    localparam logic [FAW:0] FIFO_FULL = (FAW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_INIT  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ras [RAS_DEPTH];
    logic [RAW-1:0]  r_ras_top;
    logic [RAW:0]    r_ras_cnt;
    logic [31:0]     r_fifo_instr  [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_pc     [FIFO_DEPTH];
    logic            r_fifo_taken  [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_target [FIFO_DEPTH];
    logic [FAW-1:0]  r_wr_idx;
    logic [FAW-1:0]  r_rd_idx;
    logic [FAW:0]    r_fifo_cnt;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic            w_rd_link;
    logic            w_rs1_link;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_is_branch;
    logic [XLEN-1:0] w_j_imm;
    logic [XLEN-1:0] w_b_imm;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_ras_top_val;
    logic [XLEN-1:0] w_target;
    logic            w_taken;
    logic            w_ras_pop;
    logic            w_ras_push;
    logic [RAW-1:0]  w_ras_top_popped;
    logic [RAW-1:0]  w_ras_top_nxt;
    logic [RAW:0]    w_ras_cnt_popped;
    logic [RAW:0]    w_ras_cnt_nxt;
    logic            w_run;
    logic            w_fifo_full;
    logic            w_accept;
    logic            w_fifo_pop;

    // Gating with rst_n keeps every output quiet during the reset cycle itself.
    assign w_run       = rst_n & (r_state == ST_RUN);
    assign w_fifo_full = (r_fifo_cnt == FIFO_FULL);

    assign fetch_req_o   = w_run;
    assign fetch_pc_o    = w_run ? r_pc : '0;
    assign instr_ready_o = w_run & ~w_fifo_full & ~flush_i;
    assign w_accept      = instr_valid_i & instr_ready_o;

    assign out_valid_o       = rst_n & (r_fifo_cnt != '0);
    assign w_fifo_pop        = out_valid_o & out_ready_i;
    assign out_instr_o       = out_valid_o ? r_fifo_instr[r_rd_idx]  : '0;
    assign out_pc_o          = out_valid_o ? r_fifo_pc[r_rd_idx]     : '0;
    assign out_pred_taken_o  = out_valid_o & r_fifo_taken[r_rd_idx];
    assign out_pred_target_o = out_valid_o ? r_fifo_target[r_rd_idx] : '0;

    assign w_opcode    = instr_i[6:0];
    assign w_rd        = instr_i[11:7];
    assign w_rs1       = instr_i[19:15];
    assign w_rd_link   = (w_rd == 5'd1) | (w_rd == 5'd5);
    assign w_rs1_link  = (w_rs1 == 5'd1) | (w_rs1 == 5'd5);
    assign w_is_jal    = (w_opcode == OP_JAL);
    assign w_is_jalr   = (w_opcode == OP_JALR);
    assign w_is_branch = (w_opcode == OP_BRANCH);

    assign w_j_imm = {{(XLEN - 20){instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21],
                      1'b0};
    assign w_b_imm = {{(XLEN - 12){instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8],
                      1'b0};
    assign w_pc_plus4    = r_pc + XLEN'(4);
    assign w_ras_top_val = r_ras[r_ras_top - RAW'(1)];

    // A call that is also a return (rs1 != rd, both link registers) pops before it pushes.
    assign w_ras_pop  = w_is_jalr & w_rs1_link & ((w_rd == 5'd0) | (w_rd_link & (w_rs1 != w_rd)))
                        & (r_ras_cnt != '0);
    assign w_ras_push = (w_is_jal | w_is_jalr) & w_rd_link;

    assign w_ras_top_popped = w_ras_pop ? r_ras_top - RAW'(1) : r_ras_top;
    assign w_ras_cnt_popped = w_ras_pop ? r_ras_cnt - (RAW + 1)'(1) : r_ras_cnt;
    assign w_ras_top_nxt    = w_ras_push ? w_ras_top_popped + RAW'(1) : w_ras_top_popped;
    assign w_ras_cnt_nxt    = (w_ras_push && (w_ras_cnt_popped != RAS_FULL)) ?
                              w_ras_cnt_popped + (RAW + 1)'(1) : w_ras_cnt_popped;

    always_comb begin
        w_taken  = 1'b0;
        w_target = w_pc_plus4;
        if (w_is_jal) begin
            w_taken  = 1'b1;
            w_target = r_pc + w_j_imm;
        end else if (w_is_jalr && w_ras_pop) begin
            w_taken  = 1'b1;
            w_target = w_ras_top_val;
        end else if (w_is_branch && instr_i[31]) begin
            w_taken  = 1'b1;
            w_target = r_pc + w_b_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RESET;
            r_pc       <= '0;
            r_ras_top  <= '0;
            r_ras_cnt  <= '0;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            case (r_state)
                ST_RESET: r_state <= ST_INIT;
                ST_INIT: begin
                    r_pc    <= start_address;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (flush_i) begin
                        r_pc       <= flush_pc_i;
                        r_wr_idx   <= '0;
                        r_rd_idx   <= '0;
                        r_fifo_cnt <= '0;
                    end else begin
                        if (w_accept) begin
                            r_pc      <= w_target;
                            r_ras_top <= w_ras_top_nxt;
                            r_ras_cnt <= w_ras_cnt_nxt;
                            r_wr_idx  <= r_wr_idx + FAW'(1);
                        end
                        if (w_fifo_pop) begin
                            r_rd_idx <= r_rd_idx + FAW'(1);
                        end
                        if (w_accept && !w_fifo_pop) begin
                            r_fifo_cnt <= r_fifo_cnt + (FAW + 1)'(1);
                        end else if (!w_accept && w_fifo_pop) begin
                            r_fifo_cnt <= r_fifo_cnt - (FAW + 1)'(1);
                        end
                    end
                end
                default: r_state <= ST_RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fifo_instr[r_wr_idx]  <= instr_i;
            r_fifo_pc[r_wr_idx]     <= r_pc;
            r_fifo_taken[r_wr_idx]  <= w_taken;
            r_fifo_target[r_wr_idx] <= w_target;
            if (w_ras_push) begin
                r_ras[w_ras_top_popped] <= w_pc_plus4;
            end
        end
    end
endmodule

// File: tb/tb_pc_predict_gen.sv
// Scoreboard bench for pc_predict_gen: a queue-based prediction model fills an expected-output
// queue on every accept, and an independent monitor checks each FIFO pop against it.
module tb_pc_predict_gen;
    localparam int XLEN       = 32;
    localparam int RAS_DEPTH  = 4;
    localparam int FIFO_DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] JAL_X1_100 = 32'h1000_00EF;
    localparam logic [31:0] RET = 32'h0000_8067;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] start_address = '0;
    logic            fetch_req_o;
    logic [XLEN-1:0] fetch_pc_o;
    logic [31:0]     instr_i = '0;
    logic            instr_valid_i = 1'b0;
    logic            instr_ready_o;
    logic            out_valid_o;
    logic            out_ready_i = 1'b1;
    logic [31:0]     out_instr_o;
    logic [XLEN-1:0] out_pc_o;
    logic            out_pred_taken_o;
    logic [XLEN-1:0] out_pred_target_o;
    logic            flush_i = 1'b0;
    logic [XLEN-1:0] flush_pc_i = '0;

    pc_predict_gen #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_address    (start_address),
        .fetch_req_o      (fetch_req_o),
        .fetch_pc_o       (fetch_pc_o),
        .instr_i          (instr_i),
        .instr_valid_i    (instr_valid_i),
        .instr_ready_o    (instr_ready_o),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_instr_o      (out_instr_o),
        .out_pc_o         (out_pc_o),
        .out_pred_taken_o (out_pred_taken_o),
        .out_pred_target_o(out_pred_target_o),
        .flush_i          (flush_i),
        .flush_pc_i       (flush_pc_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ras_m[$];
    logic [31:0] m_pc = '0;
    int          m_occ = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic ras_push(input logic [31:0] v);
        ras_m.push_back(v);
        if (ras_m.size() > RAS_DEPTH) ras_m.delete(0);
    endtask

    // Prediction rules applied directly to the accepted instruction.
    task automatic model_accept(input logic [31:0] ins);
        logic [4:0]  rd;
        logic [4:0]  rs1;
        bit          rdl;
        bit          rs1l;
        bit          tk;
        logic [31:0] tgt;
        int          off;
        exp_t        e;
        rd   = ins[11:7];
        rs1  = ins[19:15];
        rdl  = (rd == 1) || (rd == 5);
        rs1l = (rs1 == 1) || (rs1 == 5);
        tk   = 0;
        tgt  = m_pc + 4;
        case (ins[6:0])
            7'b1101111: begin
                off = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
                tk  = 1;
                tgt = m_pc + off;
                if (rdl) ras_push(m_pc + 4);
            end
            7'b1100111: begin
                if (rs1l && (rd == 0 || (rdl && rs1 != rd)) && ras_m.size() > 0) begin
                    tk  = 1;
                    tgt = ras_m.pop_back();
                end
                if (rdl) ras_push(m_pc + 4);
            end
            7'b1100011: begin
                if (ins[31]) begin
                    off = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
                    tk  = 1;
                    tgt = m_pc + off;
                end
            end
            default: ;
        endcase
        e = '{instr: ins, pc: m_pc, taken: tk, target: tgt};
        exp_q.push_back(e);
        m_pc = tgt;
    endtask

    // Observer: tracks PC, FIFO occupancy and handshakes that the next edge will commit.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", out_valid_o, m_occ != 0);
            if (fetch_req_o) begin
                chk("fetch_pc", fetch_pc_o, m_pc);
                chk("instr_ready", instr_ready_o, !flush_i && m_occ < FIFO_DEPTH);
                if (flush_i) begin
                    m_pc  = flush_pc_i;
                    m_occ = 0;
                    exp_q.delete();
                end else begin
                    if (out_valid_o && out_ready_i) m_occ--;
                    if (instr_valid_i && instr_ready_o) begin
                        m_occ++;
                        model_accept(instr_i);
                    end
                end
            end
        end
    end

    // Monitor: every committed pop must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !flush_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_pc", out_pc_o, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("out_instr", out_instr_o, e.instr);
                chk("out_pc", out_pc_o, e.pc);
                chk("out_taken", out_pred_taken_o, e.taken);
                chk("out_target", out_pred_target_o, e.target);
            end
        end
    end

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd5;
            default: return 5'd2;
        endcase
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    function automatic logic [31:0] rand_instr();
        case ($urandom_range(5))
            0: return NOP;
            1: return enc_j(pick_reg(), 21'($urandom) & 21'h1FFFFE);
            2, 3: return enc_jalr(pick_reg(), pick_reg());
            4: return enc_b(13'($urandom) & 13'h1FFE);
            default: return $urandom;
        endcase
    endfunction

    // Entry and exit of the tasks below are one time unit after a rising edge.
    task automatic do_reset(input logic [31:0] start);
        int n;
        rst_n         = 1'b0;
        instr_valid_i = 1'b0;
        flush_i       = 1'b0;
        start_address = start;
        @(posedge clk);
        @(negedge clk);
        chk("rst_fetch_req", fetch_req_o, 0);
        chk("rst_fetch_pc", fetch_pc_o, 0);
        chk("rst_instr_ready", instr_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_pc", out_pc_o, 0);
        m_pc  = start;
        m_occ = 0;
        exp_q.delete();
        ras_m.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fetch_req_o && n < 10);
        chk("run_reached", fetch_req_o, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, output logic [31:0] pc_at);
        int n;
        instr_i       = ins;
        instr_valid_i = 1'b1;
        n = 0;
        pc_at = 'x;
        while (1) begin
            @(negedge clk);
            if (instr_ready_o) begin
                pc_at = fetch_pc_o;
                break;
            end
            n++;
            if (n > 50) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1 instr_valid_i = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        flush_i    = 1'b1;
        flush_pc_i = pc;
        @(posedge clk);
        #1 flush_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        int acc;

        // Straight-line NOPs from the start address.
        do_reset(32'h1000);
        issue(NOP, pc); chk("nop0_pc", pc, 32'h1000);
        issue(NOP, pc); chk("nop1_pc", pc, 32'h1004);
        issue(NOP, pc); chk("nop2_pc", pc, 32'h1008);

        // Call then return.
        redirect(32'h2000);
        issue(JAL_X1_100, pc); chk("jal_pc", pc, 32'h2000);
        issue(RET, pc);        chk("jal_target", pc, 32'h2100);
        issue(NOP, pc);        chk("ret_target", pc, 32'h2004);

        // Backward branch taken, forward branch not taken.
        redirect(32'h3008);
        issue(32'hFE00_0CE3, pc); chk("beq_back_pc", pc, 32'h3008);
        issue(enc_b(13'h008), pc); chk("beq_back_target", pc, 32'h3000);
        issue(NOP, pc);            chk("beq_fwd_target", pc, 32'h3004);

        // Backpressure: two accepts fill the FIFO, then the PC holds.
        out_ready_i = 1'b0;
        redirect(32'h4000);
        instr_i       = NOP;
        instr_valid_i = 1'b1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (instr_ready_o) acc++;
        end
        chk("bp_accepts", acc, 2);
        chk("bp_ready_low", instr_ready_o, 0);
        chk("bp_pc_hold", fetch_pc_o, 32'h4008);
        @(posedge clk);
        #1 out_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_first_pop_ready", instr_ready_o, 0);
        @(negedge clk);
        chk("bp_resume_ready", instr_ready_o, 1);
        @(posedge clk);
        #1 instr_valid_i = 1'b0;

        // Nested calls overflow the return stack; the fifth return finds it empty.
        do_reset(32'h100);
        for (int i = 0; i < 5; i++) issue(JAL_X1_100, pc);
        issue(RET, pc); chk("ras_ret0_pc", pc, 32'h600);
        issue(RET, pc); chk("ras_ret1_pc", pc, 32'h504);
        issue(RET, pc); chk("ras_ret2_pc", pc, 32'h404);
        issue(RET, pc); chk("ras_ret3_pc", pc, 32'h304);
        issue(RET, pc); chk("ras_ret4_pc", pc, 32'h204);
        issue(NOP, pc); chk("ras_empty_fallthrough", pc, 32'h208);

        // Flush with a full FIFO and a competing instruction.
        do_reset(32'h7000);
        out_ready_i = 1'b0;
        issue(JAL_X1_100, pc);
        issue(NOP, pc); chk("fl_second_pc", pc, 32'h7100);
        flush_i       = 1'b1;
        flush_pc_i    = 32'h8000;
        instr_i       = JAL_X1_100;
        instr_valid_i = 1'b1;
        out_ready_i   = 1'b1;
        @(posedge clk);
        #1;
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        @(negedge clk);
        chk("fl_out_valid", out_valid_o, 0);
        chk("fl_fetch_pc", fetch_pc_o, 32'h8000);
        @(posedge clk);
        #1;
        issue(RET, pc); chk("fl_ret_pc", pc, 32'h8000);
        issue(NOP, pc); chk("fl_ras_kept", pc, 32'h7004);

        // Randomized traffic with occasional flushes and one mid-run reset.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset($urandom & 32'hFFFF_FFFC);
            instr_i       = rand_instr();
            instr_valid_i = ($urandom_range(3) != 0);
            out_ready_i   = ($urandom_range(2) != 0);
            flush_i       = ($urandom_range(39) == 0);
            flush_pc_i    = $urandom & 32'hFFFF_FFFC;
            @(posedge clk);
            #1;
        end
        instr_valid_i = 1'b0;
        flush_i       = 1'b0;
        out_ready_i   = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
